// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/flag inputs and datapath control outputs of the multicycle controller
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       IllegalOp;
  logic [3:0] State;
  modport master (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, MemtoReg, RegWrite, IllegalOp, State
  );
  modport slave (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, MemtoReg, RegWrite, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the datapath of a multicycle MIPS-style core
module multicycle_ctrl (
  input logic         clk,
  input logic         rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctl_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  state_t state, nxt;
  ctl_t   ctl, o;
  logic   legal;
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:   c.alusrcb = 2'b11;
      MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMREAD:  c.iord = 1'b1;
      MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:   c.regwrite = 1'b1;
      JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction
  assign legal = bus.Op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = DECODE;
      DECODE:   nxt = (bus.Op == OP_LW || bus.Op == OP_SW) ? MEMADR :
                      bus.Op == OP_R    ? EXECUTE  :
                      bus.Op == OP_BEQ  ? BRANCH   :
                      bus.Op == OP_ADDI ? ADDIEXEC :
                      bus.Op == OP_J    ? JUMP     : FETCH;
      MEMADR:   nxt = bus.Op == OP_SW ? MEMWR : MEMREAD;
      MEMREAD:  nxt = MEMWB;
      EXECUTE:  nxt = ALUWB;
      ADDIEXEC: nxt = ADDIWB;
      default:  nxt = FETCH;
    endcase
  end
  // outputs are registered alongside the state, so they settle with it on the same edge
  always_ff @(posedge clk) begin
    state <= rst ? FETCH : nxt;
    ctl   <= decode(rst ? FETCH : nxt);
  end
  assign o             = state > JUMP ? '0 : ctl;
  assign bus.IorD      = o.iord;
  assign bus.MemWrite  = o.memwrite;
  assign bus.IRWrite   = o.irwrite;
  assign bus.PCSrc     = o.pcsrc;
  assign bus.ALUSrcA   = o.alusrca;
  assign bus.ALUSrcB   = o.alusrcb;
  assign bus.ALUOp     = o.aluop;
  assign bus.RegDst    = o.regdst;
  assign bus.MemtoReg  = o.memtoreg;
  assign bus.RegWrite  = o.regwrite;
  assign bus.PCEn      = o.pcwrite | (o.branch & bus.Zero);
  assign bus.IllegalOp = state == DECODE && !legal;
  assign bus.State     = state;
endmodule
